// File: rtl/line_cache_reader_pkg.sv
// line_cache_reader_pkg: shared sizes, FSM states and FIFO entry type for the line reader.
package line_cache_reader_pkg;
  localparam int DEF_WIDTH = 640;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic last;
  } pixel_t;
endpackage

// File: rtl/line_cache_reader_if.sv
// line_cache_reader_if: control, cache read port and pixel stream of one line reader.
interface line_cache_reader_if;
  import line_cache_reader_pkg::*;
  logic start, busy, out_valid, out_ready, out_last, done;
  logic [ADDR_W-1:0] read_adx;
  logic [DATA_W-1:0] rdata, out_data;
  modport master(input start, rdata, out_ready, output busy, read_adx, out_data, out_valid, out_last, done);
  modport slave(output start, rdata, out_ready, input busy, read_adx, out_data, out_valid, out_last, done);
endinterface

// File: rtl/line_cache_reader_skid_fifo2.sv
// skid_fifo2: 2-entry FIFO absorbing the cache read latency under backpressure.
module skid_fifo2
  import line_cache_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  pixel_t     din,
  output pixel_t     head,
  output logic [1:0] count
);
  pixel_t mem [2];
  logic wp, rp;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  assign head = mem[rp];
  // the reader's issue rule must keep the FIFO from ever overflowing
  assert property (@(posedge clk) disable iff (reset) !(push && count == 2'd2));
endmodule

// File: rtl/line_cache_reader.sv
// line_cache_reader: sweeps line_cache addresses 0..WIDTH-1 and re-emits the line as a
// valid/ready pixel stream with last marking and a done pulse.
module line_cache_reader
  import line_cache_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic reset,
  line_cache_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADX = ADDR_W'(WIDTH - 1);
  state_t state, nstate;
  logic inflight, inflight_last, pop, issue, last_issue;
  logic [1:0] count;
  pixel_t head;
  assign pop = bus.out_valid & bus.out_ready;
  // outstanding reads plus buffered pixels, after this cycle's pop, must leave room
  assign issue = state == READ && (3'(count) + 3'(inflight) - 3'(pop)) < 3'd2;
  assign last_issue = issue && bus.read_adx == LAST_ADX;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = count != 2'd0;
  assign bus.out_data = head.data;
  assign bus.out_last = head.last & bus.out_valid;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = bus.start ? READ : IDLE;
      READ:    nstate = last_issue ? DRAIN : READ;
      DRAIN:   nstate = pop && bus.out_last ? IDLE : DRAIN;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.read_adx <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= nstate;
      inflight <= issue;
      inflight_last <= last_issue;
      bus.done <= state == DRAIN && pop && bus.out_last;
      if (state == IDLE && bus.start) bus.read_adx <= '0;
      else if (issue && !last_issue) bus.read_adx <= bus.read_adx + 1'b1;
    end
  skid_fifo2 u_fifo (
    .clk(clk),
    .reset(reset),
    .push(inflight),
    .pop(pop),
    .din('{data: bus.rdata, last: inflight_last}),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_line_cache_reader.sv
// tb_line_cache_reader: scoreboard bench for the line reader against a behavioural
// 1-cycle-latency line cache holding mem[i] = 3*i.
module tb_line_cache_reader;
  import line_cache_reader_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q [$];
  logic [8:0] got, exp_v;
  logic [3:0] ctl, exp_ctl;
  always #5 clk = ~clk;
  line_cache_reader_if bus8();
  line_cache_reader_if bus640();
  line_cache_reader #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.master));
  line_cache_reader #(.WIDTH(640)) dut640 (.clk(clk), .reset(reset), .bus(bus640.master));
  always @(posedge clk) begin
    bus8.rdata <= 8'(3 * bus8.read_adx);
    bus640.rdata <= 8'(3 * bus640.read_adx);
  end
  task automatic sb_line();
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 8'(3 * i)});
  endtask
  task automatic start_pulse();
    bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
  endtask
  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus8.busy, bus8.out_valid, bus8.out_last, bus8.done, bus8.out_data, bus8.read_adx} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_w8 got %h exp 0", {bus8.busy, bus8.out_valid, bus8.out_last, bus8.done, bus8.out_data, bus8.read_adx});
    end
    n_checks++;
    if ({bus640.busy, bus640.out_valid, bus640.out_last, bus640.done, bus640.out_data, bus640.read_adx} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_w640 got %h exp 0", {bus640.busy, bus640.out_valid, bus640.out_last, bus640.done, bus640.out_data, bus640.read_adx});
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic test_full_rate();
    bus8.out_ready = 1'b1;
    sb_line();
    start_pulse();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      ctl = {bus8.busy, bus8.out_valid, bus8.out_last, bus8.done};
      exp_ctl = {c <= 10, c >= 3 && c <= 10, c == 10, c == 11};
      n_checks++;
      if (ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL full_rate_ctl cycle %0d got %b exp %b", c, ctl, exp_ctl);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        got = {bus8.out_last, bus8.out_data};
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL full_rate_pixel cycle %0d got %h exp %h", c, got, exp_v);
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_rate_count got %0d left exp 0", exp_q.size());
    end
  endtask
  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int hs = 0, nd = 0;
    logic stall = 1'b0;
    logic [8:0] held = '0;
    sb_line();
    start_pulse();
    for (int c = 1; c <= 40; c++) begin
      bus8.out_ready = pat[c % 6];
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if ({bus8.out_valid, bus8.out_last, bus8.out_data} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL bp_hold cycle %0d got %h exp %h", c, {bus8.out_valid, bus8.out_last, bus8.out_data}, {1'b1, held});
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        got = {bus8.out_last, bus8.out_data};
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        hs++;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL bp_pixel cycle %0d got %h exp %h", c, got, exp_v);
        end
      end
      n_checks++;
      if (int'(bus8.read_adx) > hs + 2) begin
        n_fail++;
        $display("FAIL bp_ahead cycle %0d got adx %0d exp <= %0d", c, bus8.read_adx, hs + 2);
      end
      if (bus8.done) nd++;
      stall = bus8.out_valid && !bus8.out_ready;
      held = {bus8.out_last, bus8.out_data};
      @(posedge clk);
      #1;
    end
    bus8.out_ready = 1'b1;
    n_checks++;
    if (hs != 8 || nd != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_totals got hs=%0d done=%0d left=%0d exp 8 1 0", hs, nd, exp_q.size());
    end
  endtask
  task automatic test_start_while_busy();
    int hs = 0, nd = 0;
    bus8.out_ready = 1'b1;
    sb_line();
    start_pulse();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus8.out_valid && bus8.out_ready) begin
        got = {bus8.out_last, bus8.out_data};
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        hs++;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL busy_start_pixel cycle %0d got %h exp %h", c, got, exp_v);
        end
      end
      if (bus8.done) nd++;
      @(posedge clk);
      #1 bus8.start = (c == 3);
    end
    n_checks++;
    if (hs != 8 || nd != 1 || bus8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_totals got hs=%0d done=%0d busy=%b exp 8 1 0", hs, nd, bus8.busy);
    end
  endtask
  task automatic test_reset_mid_line();
    int hs = 0, nd = 0;
    bus8.out_ready = 1'b1;
    sb_line();
    start_pulse();
    for (int c = 0; c < 20 && hs < 3; c++) begin
      @(negedge clk);
      if (bus8.out_valid && bus8.out_ready) begin
        got = {bus8.out_last, bus8.out_data};
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        hs++;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL midreset_pre_pixel got %h exp %h", got, exp_v);
        end
      end
    end
    n_checks++;
    if (hs != 3) begin
      n_fail++;
      $display("FAIL midreset_wait got %0d handshakes exp 3", hs);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus8.busy, bus8.out_valid, bus8.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_abort got %b exp 000", {bus8.busy, bus8.out_valid, bus8.done});
    end
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    hs = 0;
    sb_line();
    start_pulse();
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus8.out_valid && bus8.out_ready) begin
        got = {bus8.out_last, bus8.out_data};
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        hs++;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL midreset_post_pixel cycle %0d got %h exp %h", c, got, exp_v);
        end
      end
      if (bus8.done) nd++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (hs != 8 || nd != 1) begin
      n_fail++;
      $display("FAIL midreset_totals got hs=%0d done=%0d exp 8 1", hs, nd);
    end
  endtask
  task automatic test_back_to_back();
    bus8.out_ready = 1'b1;
    sb_line();
    sb_line();
    start_pulse();
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      ctl = {bus8.busy, bus8.out_valid, bus8.out_last, bus8.done};
      exp_ctl = {c <= 10 || (c >= 12 && c <= 21), (c >= 3 && c <= 10) || (c >= 14 && c <= 21),
                 c == 10 || c == 21, c == 11 || c == 22};
      n_checks++;
      if (ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL b2b_ctl cycle %0d got %b exp %b", c, ctl, exp_ctl);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        got = {bus8.out_last, bus8.out_data};
        exp_v = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_pixel cycle %0d got %h exp %h", c, got, exp_v);
        end
      end
      @(posedge clk);
      #1 bus8.start = (c == 10);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count got %0d left exp 0", exp_q.size());
    end
  endtask
  task automatic test_wide();
    int n = 0, nl = 0, li = -1, nd = 0, mx = 0;
    bus640.out_ready = 1'b1;
    bus640.start = 1'b1;
    @(posedge clk);
    #1 bus640.start = 1'b0;
    for (int c = 1; c <= 660; c++) begin
      @(negedge clk);
      if (int'(bus640.read_adx) > mx) mx = int'(bus640.read_adx);
      if (bus640.out_valid && bus640.out_ready) begin
        n_checks++;
        if (bus640.out_data !== 8'(3 * n)) begin
          n_fail++;
          $display("FAIL wide_pixel %0d got %h exp %h", n, bus640.out_data, 8'(3 * n));
        end
        if (bus640.out_last) begin
          nl++;
          li = n;
        end
        n++;
      end
      if (bus640.done) nd++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (mx != 639 || n != 640 || nl != 1 || li != 639 || nd != 1) begin
      n_fail++;
      $display("FAIL wide_totals got max=%0d hs=%0d lasts=%0d last_at=%0d done=%0d exp 639 640 1 639 1", mx, n, nl, li, nd);
    end
  endtask
  initial begin
    bus8.start = 1'b0;
    bus8.out_ready = 1'b1;
    bus640.start = 1'b0;
    bus640.out_ready = 1'b1;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_line();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
